// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mispredict and MEM wait handling.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_mem_ren,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_flush,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;
  logic       timeout_hit;
  logic       flush_sel;
  logic       stall_sel;

  assign load_use = i_ex_mem_ren && (i_ex_rd_addr != 5'd0) &&
                    ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                     (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  // wait_cnt_q counts stall cycles already spent; this cycle would be the next one
  assign timeout_hit = (({1'b0, wait_cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= FLUSH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    flush_sel     = 1'b0;
    stall_sel     = 1'b0;
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_en     = 1'b1;
    o_idex_flush  = 1'b0;
    o_exmem_en    = 1'b1;
    o_memwb_flush = 1'b0;
    o_mem_timeout = 1'b0;

    case (state_q)
      FLUSH: begin
        flush_sel = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (i_mem_req && !i_mem_ack) begin
          stall_sel  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d       = RUN;
          o_mem_timeout = 1'b1;
        end else begin
          stall_sel  = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        flush_sel = 1'b1;
        state_d   = FLUSH;
      end
    endcase

    // A pending mispredict is held in EX during a stall and serviced on release
    if (flush_sel) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_memwb_flush = 1'b1;
    end else if (stall_sel) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_memwb_flush = 1'b1;
    end else if (i_ex_mispred) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
    end else if (load_use) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_flush  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Outside FLUSH, ifid_flush is only ever raised by a mispredict
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!o_pc_en && (state_q != FLUSH) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (o_ifid_flush && (state_q != FLUSH) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_flush_count  = flush_cnt_q;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule
